// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up sequence: pause, PRECHARGE-all, N auto-refreshes, MRS.
// On success it exports the programmed mode fields and raises ready_o. Otherwise it latches the first violation code.
module sdram_init_monitor #(
    parameter int MIN_PAUSE_CYCLES = 33334,
    parameter int MIN_AR_COUNT     = 8,
    parameter int TRP_CYCLES       = 3,
    parameter int TRC_CYCLES       = 7,
    parameter int TMRD_CYCLES      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  cmd_i,
    input  logic [11:0] a_i,
    input  logic [1:0]  bs_i,
    output logic        ready_o,
    output logic        error_o,
    output logic [2:0]  err_code_o,
    output logic [3:0]  ar_count_o,
    output logic [2:0]  burst_length_o,
    output logic        addressing_mode_o,
    output logic [2:0]  cas_latency_o,
    output logic        write_mode_o
);

    localparam int PW = $clog2(MIN_PAUSE_CYCLES + 1);
    localparam logic [PW-1:0] PAUSE_MAX = PW'(MIN_PAUSE_CYCLES);
    localparam logic [7:0]    TRP_G     = 8'(TRP_CYCLES);
    localparam logic [7:0]    TRC_G     = 8'(TRC_CYCLES);
    localparam logic [7:0]    TMRD_G    = 8'(TMRD_CYCLES);
    localparam logic [3:0]    AR_MIN    = 4'(MIN_AR_COUNT);

    typedef enum logic [2:0] {
        WAIT_PAUSE_S, WAIT_AR_S, WAIT_MRD_S, READY_S, ERROR_S
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_EARLY     = 3'd1,
        ERR_ILLEGAL   = 3'd2,
        ERR_TRP       = 3'd3,
        ERR_TRC       = 3'd4,
        ERR_AR_SHORT  = 3'd5,
        ERR_BAD_PRE   = 3'd6,
        ERR_BAD_MODE  = 3'd7
    } err_e;

    state_e          state_q, state_d;
    err_e            err_code_q, err_code_d;
    logic [PW-1:0]   pause_q, pause_d;
    logic [7:0]      gap_q, gap_d;
    logic [3:0]      ar_count_q, ar_count_d;
    logic            last_ar_q, last_ar_d;
    logic [2:0]      bl_q, bl_d;
    logic            am_q, am_d;
    logic [2:0]      cl_q, cl_d;
    logic            wm_q, wm_d;

    logic            is_idle, is_pre, is_ar, is_mrs, bad_mode;
    logic            raise;
    err_e            raise_code;

    assign is_idle  = cmd_i[3] || (cmd_i == 4'b0111);
    assign is_pre   = (cmd_i == 4'b0010);
    assign is_ar    = (cmd_i == 4'b0001);
    assign is_mrs   = (cmd_i == 4'b0000);
    assign bad_mode = (a_i[8:7] != 2'b00) || (a_i[11:10] != 2'b00) || (bs_i != 2'b00);

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        ar_count_d = ar_count_q;
        last_ar_d  = last_ar_q;
        bl_d       = bl_q;
        am_d       = am_q;
        cl_d       = cl_q;
        wm_d       = wm_q;
        raise      = 1'b0;
        raise_code = ERR_NONE;
        pause_d    = (pause_q == PAUSE_MAX) ? pause_q : pause_q + 1'b1;
        gap_d      = !is_idle ? 8'd1 : ((gap_q == 8'hFF) ? gap_q : gap_q + 8'd1);

        case (state_q)
            WAIT_PAUSE_S: begin
                if (!is_idle) begin
                    raise = 1'b1;
                    if (pause_q < PAUSE_MAX) raise_code = ERR_EARLY;
                    else if (!is_pre)        raise_code = ERR_ILLEGAL;
                    else if (!a_i[10])       raise_code = ERR_BAD_PRE;
                    else begin
                        raise     = 1'b0;
                        state_d   = WAIT_AR_S;
                        last_ar_d = 1'b0;
                    end
                end
            end
            WAIT_AR_S: begin
                // The gap requirement depends on whether the previous command was PRECHARGE or a refresh.
                if (is_ar) begin
                    if (gap_q < (last_ar_q ? TRC_G : TRP_G)) begin
                        raise      = 1'b1;
                        raise_code = last_ar_q ? ERR_TRC : ERR_TRP;
                    end else begin
                        ar_count_d = (ar_count_q == 4'hF) ? ar_count_q : ar_count_q + 4'd1;
                        last_ar_d  = 1'b1;
                    end
                end else if (is_mrs) begin
                    raise = 1'b1;
                    if (gap_q < TRC_G)           raise_code = last_ar_q ? ERR_TRC : ERR_TRP;
                    else if (ar_count_q < AR_MIN) raise_code = ERR_AR_SHORT;
                    else if (bad_mode)            raise_code = ERR_BAD_MODE;
                    else begin
                        raise   = 1'b0;
                        bl_d    = a_i[2:0];
                        am_d    = a_i[3];
                        cl_d    = a_i[6:4];
                        wm_d    = a_i[9];
                        state_d = WAIT_MRD_S;
                    end
                end else if (!is_idle) begin
                    raise      = 1'b1;
                    raise_code = ERR_ILLEGAL;
                end
            end
            WAIT_MRD_S: begin
                if (!is_idle && (gap_q < TMRD_G)) begin
                    raise      = 1'b1;
                    raise_code = ERR_ILLEGAL;
                end else if (({1'b0, gap_q} + 9'd1) >= {1'b0, TMRD_G}) begin
                    // Move one cycle early so ready_o is visible exactly TMRD cycles after the MRS.
                    state_d = READY_S;
                end
            end
            READY_S:  ;
            ERROR_S:  ;
            default:  state_d = ERROR_S;
        endcase

        if (raise) begin
            state_d    = ERROR_S;
            err_code_d = raise_code;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= WAIT_PAUSE_S;
            err_code_q <= ERR_NONE;
            pause_q    <= '0;
            gap_q      <= '0;
            ar_count_q <= '0;
            last_ar_q  <= 1'b0;
            bl_q       <= '0;
            am_q       <= 1'b0;
            cl_q       <= '0;
            wm_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            pause_q    <= pause_d;
            gap_q      <= gap_d;
            ar_count_q <= ar_count_d;
            last_ar_q  <= last_ar_d;
            bl_q       <= bl_d;
            am_q       <= am_d;
            cl_q       <= cl_d;
            wm_q       <= wm_d;
        end
    end

    assign ready_o           = (state_q == READY_S);
    assign error_o           = (state_q == ERROR_S);
    assign err_code_o        = err_code_q;
    assign ar_count_o        = ar_count_q;
    assign burst_length_o    = bl_q;
    assign addressing_mode_o = am_q;
    assign cas_latency_o     = cl_q;
    assign write_mode_o      = wm_q;

endmodule
